pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, handshaked pipeline-stage register for the five-stage core. It replaces the fixed-field decode/execute, execute/memory and memory/writeback registers. The payload is split into a control bundle (zeroed on flush to form a bubble) and a data bundle (optionally zeroed). Per-stage valid/ready flow control gives the stall behaviour. An optional 2-entry skid mode registers the upstream ready path while keeping full throughput.

## Interface
- CTRL_W, 11: control-bundle width (D/E default: regwrite, resultsrc, memwrite, jump, branch, alucontrol, alusrc).
- DATA_W, 184: data-bundle width (D/E default: rs1, rs2, rd1, rd2, pc, rd, immext, pcplus4, instr31_12).
- SKID, 0: 0 = single register with combinational in_ready; 1 = two-entry skid buffer with registered in_ready.
- CLR_DATA, 1: 1 = flush and reset also zero the data bundle; 0 = data is left unchanged on flush.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous kill of every held entry and of the beat offered this cycle.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage accepts a beat this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream consumes the beat this cycle.
- out_ctrl  out  CTRL_W  held control bundle.
- out_data  out  DATA_W  held data bundle.
- occ  out  2  number of held entries (0..1 when SKID=0; 0..2 when SKID=1).

## Operation
- Accept = in_valid & in_ready & !flush. Take = out_valid & out_ready.
- State is one of EMPTY, ONE or TWO. TWO is reachable only when SKID=1. occ encodes the state as 0, 1 or 2.
- **Reset (rst=1):** state goes to EMPTY; out_valid=0; out_ctrl=0; out_data=0; skid slot cleared; in_ready=0 while rst is high.
- **Flush:** state goes to EMPTY; main and skid control bundles go to 0. Data bundles go to 0 if CLR_DATA=1, otherwise they hold.
  - A beat offered in the same cycle is dropped.
  - Flush overrides take and accept; a take in the flush cycle is still treated as consumed downstream.
- **SKID=0:**
  - in_ready = !rst & (!out_valid | out_ready).
  - Accept loads the main slot and the state becomes ONE.
  - Take without accept makes the state EMPTY.
  - Otherwise the stage holds.
- **SKID=1:**
  - in_ready = !rst & (state != TWO). in_ready is a register output, with no combinational path from out_ready.
  - EMPTY: accept loads main, go to ONE.
  - ONE: accept & take loads main, stay in ONE. Accept & !take loads skid, go to TWO. Take without accept goes to EMPTY.
  - TWO: take moves skid to main, go to ONE. No accept is possible in TWO.
- out_valid = (state != EMPTY). out_ctrl and out_data always come from the main slot.
- While out_valid & !out_ready, out_ctrl and out_data are stable.
- Ordering is strict FIFO; no beat is duplicated or lost except through flush.
- Bundles pass through bit-exact; there is no arithmetic on the payload.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on out_* after edge N, in both modes.
- Throughput is 1 beat/cycle while out_ready=1, in both modes.
- SKID=1: the in_ready drop appears one cycle after the stall that caused it. The skid slot absorbs the in-flight beat.
- Flush takes effect at the next edge; out_valid=0 in the following cycle.
- rst is asserted mid-transfer: the beat is lost and all outputs hold their reset values in the next cycle.

## Structure
- Shared package pipe_pkg holds:
  - the state enum (ST_EMPTY, ST_ONE, ST_TWO);
  - stage width constants DE_CTRL_W=11, DE_DATA_W=184, plus the EM and MW equivalents;
  - field bit-offset constants for packing and unpacking the D/E bundles.
- Sub-module pipe_slot: a (CTRL_W+DATA_W) register with load, clr_ctrl and clr_data. It is instantiated once as main, and a second time as skid under generate when SKID=1.
- Bundle pack/unpack is done in the instantiating stage, not in this block.

## Test plan
- **Pass-through.** SKID=0, out_ready=1, four beats data=0x1..0x4, ctrl=0x7FF. Expect out_valid one cycle after each beat, identical values in order, occ=1.
- **Stall hold.** SKID=0, beat data=0xDEADBEEF, then out_ready=0 for 3 cycles. Expect out_data stable at 0xDEADBEEF and in_ready=0 for those cycles; the next beat is accepted in the cycle out_ready returns to 1.
- **Skid absorb.** SKID=1, continuous input 0xA0,0xA1,0xA2, out_ready dropped for 2 cycles.
  - Expect occ reaching 2 and in_ready=0 one cycle later.
  - Expect output order 0xA0,0xA1,0xA2 with no loss, and in_ready registered.
- **Flush bubble.** Held beat ctrl=0x5A5 and in_valid=1 with flush=1. Expect next cycle out_valid=0, out_ctrl=0, occ=0, and the incoming beat never seen at the output.
  - Repeat with CLR_DATA=0: out_data retains its prior value.
- **Flush in TWO.** SKID=1, occ=2, flush=1. Expect occ=0 and in_ready=1 next cycle; the skid contents are never emitted.
- **Reset mid-stream.** rst=1 for 1 cycle while occ=1 and in_valid=1.
  - Expect all outputs 0 and in_ready=0 during reset.
  - Expect in_ready=1 and occ=0 the cycle after.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the core's pipeline-stage registers: state encoding,
// per-stage bundle widths and the D/E bundle field layout.
package pipe_pkg;

  // The encoding doubles as the occupancy count driven on occ.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam int unsigned DE_CTRL_W = 11;
  localparam int unsigned DE_DATA_W = 184;
  localparam int unsigned EM_CTRL_W = 4;
  localparam int unsigned EM_DATA_W = 101;
  localparam int unsigned MW_CTRL_W = 3;
  localparam int unsigned MW_DATA_W = 101;

  // D/E control: {regwrite, resultsrc[1:0], memwrite, jump, branch, alucontrol[3:0], alusrc}
  localparam int unsigned DE_ALUSRC_OFF   = 0;
  localparam int unsigned DE_ALUCTL_OFF   = 1;
  localparam int unsigned DE_BRANCH_OFF   = 5;
  localparam int unsigned DE_JUMP_OFF     = 6;
  localparam int unsigned DE_MEMWRITE_OFF = 7;
  localparam int unsigned DE_RESSRC_OFF   = 8;
  localparam int unsigned DE_REGWRITE_OFF = 10;

  localparam int unsigned DE_RS1_OFF  = 0;
  localparam int unsigned DE_RS2_OFF  = 5;
  localparam int unsigned DE_RD1_OFF  = 10;
  localparam int unsigned DE_RD2_OFF  = 42;
  localparam int unsigned DE_PC_OFF   = 74;
  localparam int unsigned DE_RD_OFF   = 106;
  localparam int unsigned DE_IMM_OFF  = 111;
  localparam int unsigned DE_PCP4_OFF = 143;
  localparam int unsigned DE_UIMM_OFF = 175;
  // Only the low part of instr[31:12] that execute still consumes is carried.
  localparam int unsigned DE_UIMM_W   = DE_DATA_W - DE_UIMM_OFF;

  function automatic logic [DE_CTRL_W-1:0] de_pack_ctrl(
    input logic       regwrite,
    input logic [1:0] resultsrc,
    input logic       memwrite,
    input logic       jump,
    input logic       branch,
    input logic [3:0] alucontrol,
    input logic       alusrc
  );
    logic [DE_CTRL_W-1:0] c;
    c = '0;
    c[DE_REGWRITE_OFF]      = regwrite;
    c[DE_RESSRC_OFF +: 2]   = resultsrc;
    c[DE_MEMWRITE_OFF]      = memwrite;
    c[DE_JUMP_OFF]          = jump;
    c[DE_BRANCH_OFF]        = branch;
    c[DE_ALUCTL_OFF +: 4]   = alucontrol;
    c[DE_ALUSRC_OFF]        = alusrc;
    return c;
  endfunction

  function automatic logic [DE_DATA_W-1:0] de_pack_data(
    input logic [4:0]           rs1,
    input logic [4:0]           rs2,
    input logic [31:0]          rd1,
    input logic [31:0]          rd2,
    input logic [31:0]          pc,
    input logic [4:0]           rd,
    input logic [31:0]          immext,
    input logic [31:0]          pcplus4,
    input logic [DE_UIMM_W-1:0] uimm
  );
    logic [DE_DATA_W-1:0] d;
    d = '0;
    d[DE_RS1_OFF  +: 5]         = rs1;
    d[DE_RS2_OFF  +: 5]         = rs2;
    d[DE_RD1_OFF  +: 32]        = rd1;
    d[DE_RD2_OFF  +: 32]        = rd2;
    d[DE_PC_OFF   +: 32]        = pc;
    d[DE_RD_OFF   +: 5]         = rd;
    d[DE_IMM_OFF  +: 32]        = immext;
    d[DE_PCP4_OFF +: 32]        = pcplus4;
    d[DE_UIMM_OFF +: DE_UIMM_W] = uimm;
    return d;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One control+data holding register. Reset and the clear inputs take priority
// over load, so a flush wins against a beat loaded in the same cycle.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = DE_CTRL_W,
  parameter int unsigned DATA_W = DE_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clr_ctrl_i,
  input  logic              clr_data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_ctrl_i) begin
      ctrl_q <= '0;
    end else if (load_i) begin
      ctrl_q <= ctrl_i;
    end
    if (rst_i || clr_data_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register, 1-cycle latency, full throughput.
// SKID=1 adds a second slot so in_ready comes from a flop instead of out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W   = DE_CTRL_W,
  parameter int unsigned DATA_W   = DE_DATA_W,
  parameter int unsigned SKID     = 0,
  parameter int unsigned CLR_DATA = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  pipe_state_e       state_q, state_d;
  logic              accept, take, main_load, clr_data;
  logic [CTRL_W-1:0] skid_ctrl, main_ctrl_d;
  logic [DATA_W-1:0] skid_data, main_data_d;

  assign accept   = in_valid & in_ready & ~flush;
  assign take     = out_valid & out_ready;
  assign clr_data = flush & (CLR_DATA != 0);

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          // Without a skid slot, accept already implies take.
          if (accept && take) begin
            main_load = 1'b1;
          end else if (accept && (SKID != 0)) begin
            state_d = ST_TWO;
          end else if (take) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (take) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_ctrl_d = (state_q == ST_TWO) ? skid_ctrl : in_ctrl;
  assign main_data_d = (state_q == ST_TWO) ? skid_data : in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (main_load),
    .clr_ctrl_i (flush),
    .clr_data_i (clr_data),
    .ctrl_i     (main_ctrl_d),
    .data_i     (main_data_d),
    .ctrl_o     (out_ctrl),
    .data_o     (out_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic skid_load;
      logic rdy_q;

      assign skid_load = accept & ~take & (state_q == ST_ONE);

      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (skid_load),
        .clr_ctrl_i (flush),
        .clr_data_i (clr_data),
        .ctrl_i     (in_ctrl),
        .data_i     (in_data),
        .ctrl_o     (skid_ctrl),
        .data_o     (skid_data)
      );

      always_ff @(posedge clk) begin
        if (rst) begin
          rdy_q <= 1'b1;
        end else begin
          rdy_q <= (state_d != ST_TWO);
        end
      end

      assign in_ready = ~rst & rdy_q;
    end else begin : g_noskid
      assign skid_ctrl = '0;
      assign skid_data = '0;
      assign in_ready  = ~rst & (~out_valid | out_ready);
    end
  endgenerate

  assign out_valid = (state_q != ST_EMPTY);
  assign occ       = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives four stage variants (SKID x CLR_DATA) from one stimulus stream and
// checks each against a queue model of held beats every cycle.
module tb_pipe_stage_reg;

  localparam int CW = 11;
  localparam int DW = 184;
  localparam int N  = 4;   // index bit0 = SKID, index<2 -> CLR_DATA=1

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          ir  [N];
  logic          ov  [N];
  logic [CW-1:0] oc  [N];
  logic [DW-1:0] od  [N];
  logic [1:0]    occ [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    pipe_stage_reg #(
      .CTRL_W(CW), .DATA_W(DW), .SKID(g % 2), .CLR_DATA((g < 2) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(ir[g]), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(ov[g]), .out_ready(out_ready), .out_ctrl(oc[g]), .out_data(od[g]),
      .occ(occ[g])
    );
  end

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: each stage is a FIFO of up to 1 (SKID=0) or 2 (SKID=1) beats; the
  // shown value is the head, or the last value left in the output register.
  typedef struct packed { logic [CW-1:0] c; logic [DW-1:0] d; } beat_t;
  beat_t mq   [N][2];
  beat_t mstk [N];
  int    mcnt [N];
  bit    chk_en = 1'b0;

  function automatic beat_t shown(input int i);
    return (mcnt[i] > 0) ? mq[i][0] : mstk[i];
  endfunction

  function automatic logic m_ir(input int i);
    if (rst) return 1'b0;
    if (i % 2 == 1) return (mcnt[i] < 2);
    return (mcnt[i] == 0) || out_ready;
  endfunction

  initial begin
    beat_t sh;
    logic  acc, tk;
    for (int i = 0; i < N; i++) begin
      mcnt[i] = 0;
      mstk[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        sh = shown(i);
        if (chk_en) begin
          check($sformatf("out_valid[%0d]", i), 256'(ov[i]), 256'(mcnt[i] > 0));
          check($sformatf("in_ready[%0d]", i), 256'(ir[i]), 256'(m_ir(i)));
          check($sformatf("occ[%0d]", i), 256'(occ[i]), 256'(mcnt[i]));
          check($sformatf("out_ctrl[%0d]", i), 256'(oc[i]), 256'(sh.c));
          check($sformatf("out_data[%0d]", i), 256'(od[i]), 256'(sh.d));
        end
        acc = in_valid && m_ir(i) && !flush;
        tk  = (mcnt[i] > 0) && out_ready;
        if (rst) begin
          mcnt[i] = 0;
          mstk[i] = '0;
        end else if (flush) begin
          mstk[i].c = '0;
          mstk[i].d = (i < 2) ? {DW{1'b0}} : sh.d;
          mcnt[i] = 0;
        end else begin
          if (tk) begin
            mstk[i]  = mq[i][0];
            mq[i][0] = mq[i][1];
            mcnt[i]--;
          end
          if (acc) begin
            mq[i][mcnt[i]] = {in_ctrl, in_data};
            mcnt[i]++;
          end
        end
      end
    end
  end

  initial begin
    logic [191:0] rnd;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_ctrl = '0; in_data = '0;
    tick;
    chk_en = 1'b1;
    check("rst_out_valid", 256'(ov[0]), 256'(0));
    check("rst_in_ready", 256'(ir[1]), 256'(0));
    check("rst_occ", 256'(occ[1]), 256'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 256'(ir[1]), 256'(1));

    // Pass-through
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_ctrl = 11'h7FF; in_data = DW'(k);
      tick;
      check("pt_valid", 256'(ov[0]), 256'(1));
      check("pt_data", 256'(od[0]), 256'(k));
      check("pt_ctrl", 256'(oc[0]), 256'(11'h7FF));
      check("pt_occ", 256'(occ[0]), 256'(1));
    end
    in_valid = 1'b0;
    tick;
    check("pt_drain", 256'(ov[0]), 256'(0));

    // Stall hold
    in_valid = 1'b1; in_ctrl = 11'h123; in_data = DW'(32'hDEADBEEF);
    tick;
    in_data = DW'(32'h55); out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_in_ready", 256'(ir[0]), 256'(0));
      tick;
      check("stall_data", 256'(od[0]), 256'(32'hDEADBEEF));
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_rdy", 256'(ir[0]), 256'(1));
    tick;
    check("stall_next_beat", 256'(od[0]), 256'(32'h55));
    in_valid = 1'b0;
    tick;
    tick;

    // Skid absorb
    in_valid = 1'b1; in_ctrl = 11'h0A0; in_data = DW'(8'hA0);
    tick;
    check("skid_first", 256'(od[1]), 256'(8'hA0));
    in_ctrl = 11'h0A1; in_data = DW'(8'hA1); out_ready = 1'b0;
    #1;
    check("skid_rdy_registered", 256'(ir[1]), 256'(1));
    tick;
    check("skid_occ2", 256'(occ[1]), 256'(2));
    check("skid_rdy_drop", 256'(ir[1]), 256'(0));
    check("skid_hold_a0", 256'(od[1]), 256'(8'hA0));
    in_ctrl = 11'h0A2; in_data = DW'(8'hA2);
    tick;
    check("skid_occ2_hold", 256'(occ[1]), 256'(2));
    out_ready = 1'b1;
    tick;
    check("skid_second", 256'(od[1]), 256'(8'hA1));
    check("skid_rdy_back", 256'(ir[1]), 256'(1));
    tick;
    check("skid_third", 256'(od[1]), 256'(8'hA2));
    in_valid = 1'b0;
    tick;
    check("skid_drain", 256'(ov[1]), 256'(0));

    // Flush bubble
    in_valid = 1'b1; in_ctrl = 11'h5A5; in_data = DW'(8'h77);
    tick;
    in_ctrl = 11'h3C3; in_data = DW'(8'h99); flush = 1'b1; out_ready = 1'b0;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 256'(ov[0]), 256'(0));
    check("flush_ctrl", 256'(oc[0]), 256'(0));
    check("flush_occ", 256'(occ[0]), 256'(0));
    check("flush_data_clr", 256'(od[0]), 256'(0));
    check("flush_data_keep", 256'(od[2]), 256'(8'h77));
    out_ready = 1'b1;
    tick;
    check("flush_no_ghost", 256'(ov[0]), 256'(0));

    // Flush in TWO
    in_valid = 1'b1; in_ctrl = 11'h0B0; in_data = DW'(8'hB0);
    tick;
    in_ctrl = 11'h0B1; in_data = DW'(8'hB1); out_ready = 1'b0;
    tick;
    check("two_occ", 256'(occ[1]), 256'(2));
    flush = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("two_flush_occ", 256'(occ[1]), 256'(0));
    check("two_flush_rdy", 256'(ir[1]), 256'(1));
    check("two_flush_keep", 256'(od[3]), 256'(8'hB0));
    tick;
    check("two_skid_gone", 256'(ov[1]), 256'(0));

    // Reset mid-stream
    in_valid = 1'b1; in_ctrl = 11'h0C0; in_data = DW'(8'hC0);
    tick;
    check("rms_occ", 256'(occ[0]), 256'(1));
    rst = 1'b1; in_data = DW'(8'hC1);
    #1;
    check("rms_rdy_low", 256'(ir[0]), 256'(0));
    tick;
    check("rms_valid", 256'(ov[0]), 256'(0));
    check("rms_ctrl", 256'(oc[0]), 256'(0));
    check("rms_data", 256'(od[0]), 256'(0));
    check("rms_occ0", 256'(occ[1]), 256'(0));
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rms_rdy_after", 256'(ir[0]), 256'(1));
    check("rms_occ_after", 256'(occ[0]), 256'(0));
    tick;

    // Mixed traffic, model-checked every cycle
    for (int k = 0; k < 400; k++) begin
      rnd       = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      in_ctrl   = CW'($urandom());
      in_data   = rnd[DW-1:0];
      tick;
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick;
    tick;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
